vram_emulator: RTL

VRAM_EMULATOR -- requirements
Module: vram_emulator

---
 rtl/vram_emulator_if.sv | 35 +++
 rtl/vram_emulator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vram_emulator_if.sv
// vram_emulator_if: bus bundle between the video-bus host and the VRAM emulator.
//   master: bus host (drives strobes, addresses and write data; sees read data, flags, counters)
//   slave : vram_emulator
//   vrd_n_i, vawr_n_i, vbwr_n_i : active-low read / chip A write / chip B write strobes
//   va14_i, vaa_i, vab_i        : shared high address bit, chip A / chip B addresses
//   vda_i, vdb_i                : write data sampled from the bus buffers
//   vda_o, vdb_o, vd_tristate_o : read data and buffer release (1 = release)
//   error_collision_o           : sticky read/write strobe collision flag
//   read_count_o, write_count_o : transaction counters (zero unless counters are built in)
interface vram_emulator_if;
  logic        vrd_n_i;
  logic        vawr_n_i;
  logic        vbwr_n_i;
  logic        va14_i;
  logic [13:0] vaa_i;
  logic [13:0] vab_i;
  logic [7:0]  vda_i;
  logic [7:0]  vdb_i;
  logic [7:0]  vda_o;
  logic [7:0]  vdb_o;
  logic        vd_tristate_o;
  logic        error_collision_o;
  logic [15:0] read_count_o;
  logic [15:0] write_count_o;

  modport master (
    output vrd_n_i, vawr_n_i, vbwr_n_i, va14_i, vaa_i, vab_i, vda_i, vdb_i,
    input  vda_o, vdb_o, vd_tristate_o, error_collision_o, read_count_o, write_count_o
  );

  modport slave (
    input  vrd_n_i, vawr_n_i, vbwr_n_i, va14_i, vaa_i, vab_i, vda_i, vdb_i,
    output vda_o, vdb_o, vd_tristate_o, error_collision_o, read_count_o, write_count_o
  );
endinterface

// File: rtl/vram_emulator.sv
// vram_emulator: emulates two 8-bit VRAM chips (A and B) sharing a read strobe.
// Ports:
//   clock : single clock domain
//   reset : asynchronous, active-high
//   bus   : vram_emulator_if.slave (strobes, addresses, data in/out, flags, counters)
// Parameters:
//   ADDR_BITS   : bytes per chip = 2**ADDR_BITS (8..15); address = {va14, vaX} truncated
//   SYNC_STAGES : synchronizer depth on every bus input (2..3)
// Optional feature: define VRAM_EMULATOR_COUNTERS_EN to build saturating read/write
// counters; otherwise both counter outputs are tied to zero.
module vram_emulator #(
  parameter int ADDR_BITS   = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic            clock,
  input logic            reset,
  vram_emulator_if.slave bus
);
  localparam int SS    = SYNC_STAGES;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, READ_FETCH, READ_DRIVE, WRITE} state_t;

  // Synchronizers; index [1] = chip B, [0] = chip A. Strobes reset to the inactive level.
  logic [SS-1:0][2:0]       strb_sync;  // {vbwr_n, vawr_n, vrd_n}
  logic [SS-1:0]            va14_sync;
  logic [SS-1:0][1:0][13:0] addr_sync;
  logic [SS-1:0][1:0][7:0]  data_sync;
  logic [SS-1:0]            live;       // marks when synchronizer outputs carry real samples

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      strb_sync <= '1;
      va14_sync <= '0;
      addr_sync <= '0;
      data_sync <= '0;
      live      <= '0;
    end else begin
      strb_sync <= {strb_sync[SS-2:0], bus.vbwr_n_i, bus.vawr_n_i, bus.vrd_n_i};
      va14_sync <= {va14_sync[SS-2:0], bus.va14_i};
      addr_sync <= {addr_sync[SS-2:0], bus.vab_i, bus.vaa_i};
      data_sync <= {data_sync[SS-2:0], bus.vdb_i, bus.vda_i};
      live      <= {live[SS-2:0], 1'b1};
    end

  logic                           rd_s, live_s;
  logic [1:0]                     wr_s, wr_low, wr_rise;
  logic [1:0][7:0]                data_s;
  logic [1:0][ADDR_BITS-1:0]      cur_addr;

  assign rd_s   = strb_sync[SS-1][0];
  assign wr_s   = strb_sync[SS-1][2:1];
  assign wr_low = ~wr_s;
  assign live_s = live[SS-1];
  assign data_s = data_sync[SS-1];

  state_t                    state, state_nx;
  logic                      rd_prev, lockout, err, tri_q;
  logic [1:0]                wr_prev;
  logic [1:0][7:0]           vd_q, wr_data, fetch_all;
  logic [1:0][ADDR_BITS-1:0] rd_addr, wr_addr;

  logic       collide, rd_fall, lat_rd, fetch, drive;
  logic [1:0] lat_wr, commit;

  assign collide = !rd_s && (|wr_low);
  assign rd_fall = rd_prev && !rd_s;
  assign wr_rise = ~wr_prev & wr_s;

  always_comb begin
    state_nx = state;
    lat_rd   = 1'b0;
    lat_wr   = 2'b00;
    commit   = 2'b00;
    fetch    = 1'b0;
    drive    = 1'b0;
    case (state)
      IDLE:
        if (!collide && !lockout) begin
          if (rd_fall && (&wr_s)) begin
            lat_rd   = 1'b1;
            state_nx = READ_FETCH;
          end else if (rd_s && (|wr_low)) begin
            // Latch already here so a one-cycle strobe still has data to commit.
            lat_wr   = wr_low;
            state_nx = WRITE;
          end
        end
      READ_FETCH: begin
        fetch    = 1'b1;
        state_nx = (!collide && !rd_s) ? READ_DRIVE : IDLE;
      end
      READ_DRIVE:
        if (!collide && !rd_s) drive = 1'b1;
        else                   state_nx = IDLE;
      WRITE:
        if (collide) state_nx = IDLE;  // pending bytes are dropped
        else begin
          lat_wr = wr_low;
          commit = wr_rise;
          if (&wr_s) state_nx = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= IDLE;
      rd_prev <= 1'b1;
      wr_prev <= 2'b11;
      lockout <= 1'b1;  // a strobe held low across reset must be seen high first
      err     <= 1'b0;
      tri_q   <= 1'b1;
      vd_q    <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nx;
      rd_prev <= rd_s;
      wr_prev <= wr_s;
      if (collide) err <= 1'b1;
      if (collide)                          lockout <= 1'b1;
      else if (live_s && rd_s && (&wr_s))   lockout <= 1'b0;
      tri_q <= ~drive;
      if (drive) vd_q <= fetch_all;
      for (int ch = 0; ch < 2; ch++) begin
        if (lat_rd) rd_addr[ch] <= cur_addr[ch];
        if (lat_wr[ch]) begin
          wr_addr[ch] <= cur_addr[ch];
          wr_data[ch] <= data_s[ch];
        end
      end
    end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chip
    logic [7:0] mem [DEPTH];
    logic [7:0] fetch_q;

    assign cur_addr[ch]  = ADDR_BITS'({va14_sync[SS-1], addr_sync[SS-1][ch]});
    assign fetch_all[ch] = fetch_q;

    // No reset: contents survive reset by design.
    always_ff @(posedge clock) begin
      if (commit[ch]) mem[wr_addr[ch]] <= wr_data[ch];
      if (fetch)      fetch_q <= mem[rd_addr[ch]];
    end
  end

  assign bus.vda_o             = vd_q[0];
  assign bus.vdb_o             = vd_q[1];
  // Any synchronized write strobe releases the bus at once, independent of the register.
  assign bus.vd_tristate_o     = tri_q | (|wr_low);
  assign bus.error_collision_o = err;

`ifdef VRAM_EMULATOR_COUNTERS_EN
  logic [15:0] rd_cnt, wr_cnt;
  logic [15:0] n_commit;
  logic        enter_drive;

  assign enter_drive = (state == READ_FETCH) && (state_nx == READ_DRIVE);
  assign n_commit    = {15'd0, commit[0]} + {15'd0, commit[1]};

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (enter_drive && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (wr_cnt > 16'hFFFF - n_commit) wr_cnt <= 16'hFFFF;
      else                              wr_cnt <= wr_cnt + n_commit;
    end

  assign bus.read_count_o  = rd_cnt;
  assign bus.write_count_o = wr_cnt;
`else
  assign bus.read_count_o  = 16'h0000;
  assign bus.write_count_o = 16'h0000;
`endif
endmodule
